wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (wn/d/we) among NREQ writeback requesters: ALU, load unit and multiply/divide unit.
- Each requester has a valid/ready handshake; the arbiter is round-robin.
- A one-entry registered output stage drives the register-file write port directly.
- A global stall input freezes the write port without losing pending data.

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- DW, 32, data width
- AW, 5, register number width

Ports:
- clk  input  1  clock, rising edge
- clrn  input  1  asynchronous active-low reset
- req_valid  input  NREQ  requester i has a write pending
- req_wn  input  NREQ*AW  destination register of requester i, slice [i*AW +: AW]
- req_d  input  NREQ*DW  write data of requester i, slice [i*DW +: DW]
- req_ready  output  NREQ  one-hot grant; a transfer happens when valid and ready are both high
- stall  input  1  holds the write port; no register-file write occurs
- wn  output  AW  to register-file write register number
- d  output  DW  to register-file write data
- we  output  1  to register-file write enable
- grant_id  output  clog2(NREQ)  index of the requester that owns the current output entry

Behaviour:
- Reset (clrn low, asynchronous): pend_v=0, wn=0, d=0, grant_id=0, rr_ptr=0. Therefore we=0 and req_ready=0 during reset.
- Output stage holds pend_v, wn, d and grant_id. we = pend_v & ~stall, combinational.
- accept_ok = ~pend_v | ~stall. The stage can take a new entry in the same cycle the old one drains.
- Arbitration is combinational. Search req_valid starting at rr_ptr, ascending, wrapping modulo NREQ. The first valid requester g wins.
- req_ready[g]=1 only if accept_ok. All other ready bits are 0. At most one ready bit is high per cycle.
- On a transfer (posedge): pend_v<=1, wn<=req_wn[g], d<=req_d[g], grant_id<=g, rr_ptr<=(g+1) mod NREQ.
- No transfer and ~stall: pend_v<=0. wn, d and grant_id hold their values.
- stall=1 with pend_v=1: the entry holds, we=0, no requester is granted.
- stall=1 with pend_v=0: one transfer is still allowed, filling the stage; it then waits.
- Register 0 destination:
  - The request is accepted, consumes the grant and advances rr_ptr.
  - pend_v is NOT set, so no write is issued.
  - This avoids a wasted port cycle.
- Latency: a transfer at edge N gives we=1 during cycle N+1. The register file writes at edge N+1. Sustained throughput is 1 write per cycle with stall=0.
- rr_ptr changes only on a transfer. With no valid requests it holds.
- Requesters must keep req_valid, req_wn and req_d stable until ready. The arbiter does not check this.
- Reset mid-operation discards any pending entry; no write is issued after clrn rises until a new transfer.
- Fairness: with all requesters continuously valid and stall=0, grants rotate 0,1,...,NREQ-1,0.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, add inputs rna and rnb (AW each) and outputs fwd_a, fwd_b (1 each) and fwd_d (DW).
- fwd_a = pend_v & (rna==wn) & (rna!=0); fwd_b is the same using rnb. fwd_d = d.
- The datapath uses these to bypass the not-yet-written result. Flags are valid regardless of stall.
- Without the macro these ports do not exist and no comparators are built.

Test Plan:
- Reset, then req_valid=3'b001, req_wn[0]=5'd7, req_d[0]=32'hDEADBEEF, stall=0 -> req_ready=3'b001. Next cycle: we=1, wn=7, d=DEADBEEF, grant_id=0.
- req_valid=3'b111 held for 6 cycles, stall=0 -> grant order 0,1,2,0,1,2, one per cycle; we=1 each cycle after the first.
- Requester 1 has wn=0 and requester 2 has wn=4 → granted order 1 then 2. Requester 1 produces no write (we stays 0 for it). Requester 2 write appears the cycle after its grant.
- Pending entry, then stall=1 for 3 cycles with req_valid=3'b010 -> we=0, req_ready=0, wn/d held. Stall drop → original write issued and requester 1 granted in the same cycle.
- Assert clrn=0 asynchronously between edges while pend_v=1 -> we drops to 0 immediately. After release, no write until a new request.
- With WB_FWD_EN: pending wn=9, rna=9, rnb=0 → fwd_a=1, fwd_b=0. Also fwd_d must equal d.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter: NREQ requesters share one register-file write port.
// Optional WB_FWD_EN adds bypass flags against the pending output entry.
module wb_port_arbiter #(
  parameter  int NREQ = 3,
  parameter  int DW   = 32,
  parameter  int AW   = 5,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_wn,
  input  logic [NREQ*DW-1:0] req_d,
  output logic [NREQ-1:0]    req_ready,
  input  logic               stall,
`ifdef WB_FWD_EN
  input  logic [AW-1:0]      rna,
  input  logic [AW-1:0]      rnb,
  output logic               fwd_a,
  output logic               fwd_b,
  output logic [DW-1:0]      fwd_d,
`endif
  output logic [AW-1:0]      wn,
  output logic [DW-1:0]      d,
  output logic               we,
  output logic [GW-1:0]      grant_id
);

  logic            r_pend_v;
  logic [AW-1:0]   r_wn;
  logic [DW-1:0]   r_d;
  logic [GW-1:0]   r_gid;
  logic [GW-1:0]   r_rr_ptr;

  logic            w_accept_ok;
  logic            w_found;
  logic            w_xfer;
  logic [NREQ-1:0] w_hi_mask;
  logic [NREQ-1:0] w_cand;
  logic [GW-1:0]   w_gnt;
  logic [GW-1:0]   w_rr_nxt;
  logic [AW-1:0]   w_sel_wn;
  logic [DW-1:0]   w_sel_d;

  // Gating with clrn keeps every ready low while reset is held.
  assign w_accept_ok = clrn & (~r_pend_v | ~stall);
  assign w_found     = |req_valid;
  assign w_xfer      = w_found & w_accept_ok;

  // Requesters at or above rr_ptr take precedence; otherwise wrap to the lowest index.
  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_hi_mask[i] = (GW'(i) >= r_rr_ptr);
    end
    w_cand = (|(req_valid & w_hi_mask)) ? (req_valid & w_hi_mask) : req_valid;
  end

  always_comb begin
    w_gnt = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_cand[i]) w_gnt = GW'(i);
    end
  end

  always_comb begin
    w_sel_wn = '0;
    w_sel_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == w_gnt) begin
        w_sel_wn = req_wn[i*AW +: AW];
        w_sel_d  = req_d[i*DW +: DW];
      end
    end
  end

  assign w_rr_nxt  = (w_gnt == GW'(NREQ - 1)) ? '0 : w_gnt + GW'(1);
  assign req_ready = w_xfer ? (NREQ'(1) << w_gnt) : '0;

  // A register-0 destination still consumes the grant but never raises a write.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pend_v <= 1'b0;
      r_wn     <= '0;
      r_d      <= '0;
      r_gid    <= '0;
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_pend_v <= |w_sel_wn;
      r_wn     <= w_sel_wn;
      r_d      <= w_sel_d;
      r_gid    <= w_gnt;
      r_rr_ptr <= w_rr_nxt;
    end else if (!stall) begin
      r_pend_v <= 1'b0;
    end
  end

  assign we       = r_pend_v & ~stall;
  assign wn       = r_wn;
  assign d        = r_d;
  assign grant_id = r_gid;

`ifdef WB_FWD_EN
  assign fwd_a = r_pend_v & (rna == r_wn) & (|rna);
  assign fwd_b = r_pend_v & (rnb == r_wn) & (|rnb);
  assign fwd_d = r_d;
`endif

endmodule
